// File: rtl/w_load_pipe.sv
// MEM/WB pipeline register with write-back load extension and a retired-instruction counter.
// Optional simulation trace of GRF writes is enabled by defining W_TRACE_EN.
module w_load_pipe #(
    parameter int          RETIRE_W  = 32,
    parameter logic [31:0] RESET_PC8 = 32'h0000_3008
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                W_En,
    input  logic                W_Flush,
    input  logic                M_Valid,
    input  logic [31:0]         M_MemoryData,
    input  logic [31:0]         M_StoreAddr,
    input  logic [2:0]          M_LoadType,
    input  logic [31:0]         M_ALUResult,
    input  logic [31:0]         M_PC8,
    input  logic [4:0]          M_RegDst,
    input  logic                M_RegWrite,
    input  logic [1:0]          M_WdSel,
    output logic                W_RegWrite,
    output logic [4:0]          W_RegAddr,
    output logic [31:0]         W_RegData,
    output logic [31:0]         W_PC8,
    output logic                W_Valid,
    output logic [RETIRE_W-1:0] W_RetireCnt
);

    localparam logic [2:0] LT_LH  = 3'd2;
    localparam logic [2:0] LT_LHU = 3'd3;
    localparam logic [2:0] LT_LB  = 3'd4;
    localparam logic [2:0] LT_LBU = 3'd5;

    logic                valid_r;
    logic                reg_write_r;
    logic [4:0]          reg_dst_r;
    logic [2:0]          load_type_r;
    logic [1:0]          wd_sel_r;
    logic [1:0]          offset_r;
    logic [31:0]         data_r;
    logic [31:0]         alu_r;
    logic [31:0]         pc8_r;
    logic [RETIRE_W-1:0] retire_cnt_r;

    logic                write_en_s;
    logic [31:0]         load_data_s;
    logic [31:0]         reg_data_s;
    logic [4:0]          reg_addr_s;
    logic                unused_addr_s;

    // Select the addressed byte/half of the memory word and extend it to 32 bits.
    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [1:0]  offset,
                                                input logic [2:0]  load_type);
        logic [15:0] half_v;
        logic [7:0]  byte_v;
        logic [31:0] result_v;
        half_v = offset[1] ? word[31:16] : word[15:0];
        case (offset)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            2'd3:    byte_v = word[31:24];
            default: byte_v = word[7:0];
        endcase
        case (load_type)
            LT_LH:   result_v = {{16{half_v[15]}}, half_v};
            LT_LHU:  result_v = {16'h0000, half_v};
            LT_LB:   result_v = {{24{byte_v[7]}}, byte_v};
            LT_LBU:  result_v = {24'h00_0000, byte_v};
            default: result_v = word;
        endcase
        return result_v;
    endfunction

    // Pipeline register: reset, then flush (bubble), then stall, then capture.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_r      <= 1'b0;
            reg_write_r  <= 1'b0;
            reg_dst_r    <= 5'd0;
            load_type_r  <= 3'd0;
            wd_sel_r     <= 2'd0;
            offset_r     <= 2'd0;
            data_r       <= 32'd0;
            alu_r        <= 32'd0;
            pc8_r        <= RESET_PC8;
            retire_cnt_r <= {RETIRE_W{1'b0}};
        end else if (W_Flush) begin
            valid_r      <= 1'b0;
            reg_write_r  <= 1'b0;
            reg_dst_r    <= 5'd0;
            load_type_r  <= 3'd0;
            wd_sel_r     <= 2'd0;
            offset_r     <= 2'd0;
            data_r       <= 32'd0;
            alu_r        <= 32'd0;
            pc8_r        <= RESET_PC8;
        end else if (W_En) begin
            valid_r      <= M_Valid;
            reg_write_r  <= M_RegWrite;
            reg_dst_r    <= M_RegDst;
            load_type_r  <= M_LoadType;
            wd_sel_r     <= M_WdSel;
            offset_r     <= M_StoreAddr[1:0];
            data_r       <= M_MemoryData;
            alu_r        <= M_ALUResult;
            pc8_r        <= M_PC8;
            retire_cnt_r <= retire_cnt_r + {{(RETIRE_W-1){1'b0}}, M_Valid};
        end
    end

    // Write-back port derived purely from registered state; $0 and bubbles never write.
    always_comb begin
        write_en_s    = reg_write_r & valid_r & (reg_dst_r != 5'd0);
        load_data_s   = extend_load(data_r, offset_r, load_type_r);
        unused_addr_s = ^M_StoreAddr[31:2];
        case (wd_sel_r)
            2'd1:    reg_data_s = load_data_s;
            2'd2:    reg_data_s = pc8_r;
            default: reg_data_s = alu_r;
        endcase
        if (write_en_s) begin
            reg_addr_s = reg_dst_r;
        end else begin
            reg_addr_s = 5'd0;
        end
    end

    assign W_RegWrite  = write_en_s;
    assign W_RegAddr   = reg_addr_s;
    assign W_RegData   = reg_data_s;
    assign W_PC8       = pc8_r;
    assign W_Valid     = valid_r;
    assign W_RetireCnt = retire_cnt_r;

`ifdef W_TRACE_EN
    // Simulation trace of every GRF write.
    always @(posedge clk) begin
        if (reset && W_RegWrite) begin
            $display("@%h: $%d <= %h", W_PC8 - 32'd8, W_RegAddr, W_RegData);
        end
    end
`endif

endmodule

// File: tb/tb_w_load_pipe.sv
// Bench for w_load_pipe (RETIRE_W=4): directed scenarios plus randomized traffic vs. a reference model.
module tb_w_load_pipe;
    logic        clk = 1'b0;
    logic        reset, W_En, W_Flush, M_Valid, M_RegWrite;
    logic [31:0] M_MemoryData, M_StoreAddr, M_ALUResult, M_PC8;
    logic [2:0]  M_LoadType;
    logic [4:0]  M_RegDst;
    logic [1:0]  M_WdSel;
    logic        W_RegWrite, W_Valid;
    logic [4:0]  W_RegAddr;
    logic [31:0] W_RegData, W_PC8;
    logic [3:0]  W_RetireCnt;

    int checks = 0;
    int errors = 0;

    // reference model state: the instruction currently sitting in W
    logic        md_valid, md_rw;
    logic [4:0]  md_dst;
    logic [2:0]  md_lt;
    logic [1:0]  md_ws;
    int          md_off;
    logic [31:0] md_d, md_alu, md_pc8;
    int          md_cnt;

    w_load_pipe #(.RETIRE_W(4), .RESET_PC8(32'h0000_3008)) dut (
        .clk(clk), .reset(reset), .W_En(W_En), .W_Flush(W_Flush), .M_Valid(M_Valid),
        .M_MemoryData(M_MemoryData), .M_StoreAddr(M_StoreAddr), .M_LoadType(M_LoadType),
        .M_ALUResult(M_ALUResult), .M_PC8(M_PC8), .M_RegDst(M_RegDst),
        .M_RegWrite(M_RegWrite), .M_WdSel(M_WdSel), .W_RegWrite(W_RegWrite),
        .W_RegAddr(W_RegAddr), .W_RegData(W_RegData), .W_PC8(W_PC8),
        .W_Valid(W_Valid), .W_RetireCnt(W_RetireCnt));

    always #5 clk = ~clk;

    task automatic model_bubble();
        md_valid = 1'b0; md_rw = 1'b0; md_dst = 5'd0; md_lt = 3'd0; md_ws = 2'd0;
        md_off = 0; md_d = 32'd0; md_alu = 32'd0; md_pc8 = 32'h0000_3008;
    endtask

    task automatic model_step();
        if (!reset) begin
            model_bubble();
            md_cnt = 0;
        end else if (W_Flush) begin
            model_bubble();
        end else if (W_En) begin
            md_valid = M_Valid; md_rw = M_RegWrite; md_dst = M_RegDst; md_lt = M_LoadType;
            md_ws = M_WdSel; md_off = int'(M_StoreAddr % 32'd4); md_d = M_MemoryData;
            md_alu = M_ALUResult; md_pc8 = M_PC8;
            if (M_Valid) md_cnt = (md_cnt + 1) % 16;
        end
    endtask

    function automatic logic exp_we();
        return md_valid && md_rw && (md_dst != 5'd0);
    endfunction

    function automatic logic [4:0] exp_addr();
        return exp_we() ? md_dst : 5'd0;
    endfunction

    function automatic logic [31:0] exp_data();
        logic [31:0] part;
        if (md_ws == 2'd2) return md_pc8;
        if (md_ws != 2'd1) return md_alu;
        if (md_lt == 3'd2 || md_lt == 3'd3) begin
            part = (md_d >> (16 * (md_off / 2))) & 32'h0000_FFFF;
            if (md_lt == 3'd2 && part >= 32'h0000_8000) part = part + 32'hFFFF_0000;
            return part;
        end
        if (md_lt == 3'd4 || md_lt == 3'd5) begin
            part = (md_d >> (8 * md_off)) & 32'h0000_00FF;
            if (md_lt == 3'd4 && part >= 32'h0000_0080) part = part + 32'hFFFF_FF00;
            return part;
        end
        return md_d;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic rand_inputs();
        W_En = 1'($urandom); W_Flush = 1'($urandom); M_Valid = 1'($urandom);
        M_MemoryData = $urandom; M_StoreAddr = $urandom; M_LoadType = 3'($urandom);
        M_ALUResult = $urandom; M_PC8 = $urandom; M_RegDst = 5'($urandom);
        M_RegWrite = 1'($urandom); M_WdSel = 2'($urandom);
    endtask

    task automatic drive_load(input logic [31:0] d, input logic [1:0] a, input logic [2:0] lt);
        W_En = 1'b1; W_Flush = 1'b0; M_Valid = 1'b1; M_RegWrite = 1'b1; M_RegDst = 5'd7;
        M_WdSel = 2'd1; M_MemoryData = d; M_StoreAddr = {30'($urandom), a};
        M_LoadType = lt; M_ALUResult = $urandom; M_PC8 = $urandom;
    endtask

    task automatic test_reset();
        rand_inputs();
        reset = 1'b0;
        tick();
        rand_inputs();
        tick();
        checks++; if (W_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %h exp 0", W_Valid); end
        checks++; if (W_RegWrite !== 1'b0) begin errors++; $display("FAIL reset_we got %h exp 0", W_RegWrite); end
        checks++; if (W_RegAddr !== 5'd0) begin errors++; $display("FAIL reset_addr got %h exp 0", W_RegAddr); end
        checks++; if (W_RegData !== 32'd0) begin errors++; $display("FAIL reset_data got %h exp 0", W_RegData); end
        checks++; if (W_PC8 !== 32'h0000_3008) begin errors++; $display("FAIL reset_pc8 got %h exp 00003008", W_PC8); end
        checks++; if (W_RetireCnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %h exp 0", W_RetireCnt); end
        reset = 1'b1;
    endtask

    task automatic test_byte_loads();
        logic [31:0] bexp [5];
        logic [1:0]  boff [5];
        logic [2:0]  btyp [5];
        bexp = '{32'h0000_0001, 32'h0000_007F, 32'hFFFF_FFFF, 32'hFFFF_FF80, 32'h0000_0080};
        boff = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
        btyp = '{3'd4, 3'd4, 3'd4, 3'd4, 3'd5};
        for (int i = 0; i < 5; i++) begin
            drive_load(32'h80FF_7F01, boff[i], btyp[i]);
            tick();
            checks++;
            if (W_RegData !== bexp[i]) begin
                errors++; $display("FAIL byte_load[%0d] got %h exp %h", i, W_RegData, bexp[i]);
            end
            checks++;
            if (W_RegWrite !== 1'b1 || W_RegAddr !== 5'd7) begin
                errors++; $display("FAIL byte_load_port[%0d] got we=%h addr=%0d exp we=1 addr=7", i, W_RegWrite, W_RegAddr);
            end
        end
    endtask

    task automatic test_half_loads();
        logic [31:0] hexp [4];
        logic [1:0]  hoff [4];
        logic [2:0]  htyp [4];
        hexp = '{32'h0000_7FFE, 32'hFFFF_8001, 32'h0000_8001, 32'hFFFF_8001};
        hoff = '{2'd0, 2'd2, 2'd2, 2'd3};
        htyp = '{3'd2, 3'd2, 3'd3, 3'd2};
        for (int i = 0; i < 4; i++) begin
            drive_load(32'h8001_7FFE, hoff[i], htyp[i]);
            tick();
            checks++;
            if (W_RegData !== hexp[i]) begin
                errors++; $display("FAIL half_load[%0d] got %h exp %h", i, W_RegData, hexp[i]);
            end
        end
    endtask

    task automatic test_stall_flush();
        logic [3:0] cnt0;
        W_En = 1'b1; W_Flush = 1'b0; M_Valid = 1'b1; M_RegWrite = 1'b1; M_RegDst = 5'd5;
        M_WdSel = 2'd0; M_ALUResult = 32'h0000_1234; M_PC8 = 32'h0000_3100; M_LoadType = 3'd0;
        tick();
        cnt0 = 4'(md_cnt);
        checks++;
        if (W_RegWrite !== 1'b1 || W_RegAddr !== 5'd5 || W_RegData !== 32'h0000_1234) begin
            errors++; $display("FAIL stall_capture got we=%h addr=%0d data=%h exp we=1 addr=5 data=00001234", W_RegWrite, W_RegAddr, W_RegData);
        end
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            W_En = 1'b0; W_Flush = 1'b0;
            tick();
            checks++;
            if (W_RegWrite !== 1'b1 || W_RegAddr !== 5'd5 || W_RegData !== 32'h0000_1234 ||
                W_PC8 !== 32'h0000_3100 || W_RetireCnt !== cnt0) begin
                errors++; $display("FAIL stall_hold[%0d] got we=%h addr=%0d data=%h pc8=%h cnt=%0d exp 1 5 00001234 00003100 %0d",
                                   i, W_RegWrite, W_RegAddr, W_RegData, W_PC8, W_RetireCnt, cnt0);
            end
        end
        rand_inputs();
        W_En = 1'b0; W_Flush = 1'b1;
        tick();
        checks++;
        if (W_Valid !== 1'b0 || W_RegWrite !== 1'b0 || W_PC8 !== 32'h0000_3008 || W_RetireCnt !== cnt0) begin
            errors++; $display("FAIL flush got valid=%h we=%h pc8=%h cnt=%0d exp 0 0 00003008 %0d",
                               W_Valid, W_RegWrite, W_PC8, W_RetireCnt, cnt0);
        end
        W_Flush = 1'b0;
    endtask

    task automatic test_zero_guard_pc8();
        W_En = 1'b1; W_Flush = 1'b0; M_Valid = 1'b1; M_RegWrite = 1'b1; M_RegDst = 5'd0;
        M_WdSel = 2'd0; M_ALUResult = $urandom;
        tick();
        checks++;
        if (W_RegWrite !== 1'b0 || W_RegAddr !== 5'd0) begin
            errors++; $display("FAIL zero_guard got we=%h addr=%0d exp we=0 addr=0", W_RegWrite, W_RegAddr);
        end
        M_PC8 = 32'h0000_3010; M_RegDst = 5'd31; M_WdSel = 2'd2;
        tick();
        checks++;
        if (W_RegData !== 32'h0000_3010 || W_RegAddr !== 5'd31 || W_RegWrite !== 1'b1) begin
            errors++; $display("FAIL jal_link got data=%h addr=%0d we=%h exp 00003010 31 1", W_RegData, W_RegAddr, W_RegWrite);
        end
    endtask

    task automatic test_counter_wrap();
        reset = 1'b0;
        tick();
        reset = 1'b1; W_En = 1'b1; W_Flush = 1'b0; M_Valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            M_RegDst = 5'($urandom);
            tick();
            if (i == 14) begin
                checks++;
                if (W_RetireCnt !== 4'd15) begin errors++; $display("FAIL cnt_15 got %0d exp 15", W_RetireCnt); end
            end
        end
        checks++;
        if (W_RetireCnt !== 4'd0) begin errors++; $display("FAIL cnt_wrap got %0d exp 0", W_RetireCnt); end
        M_Valid = 1'b0;
        M_RegWrite = 1'b1; M_RegDst = 5'd9;
        tick();
        checks++;
        if (W_RetireCnt !== 4'd0 || W_Valid !== 1'b0 || W_RegWrite !== 1'b0) begin
            errors++; $display("FAIL cnt_bubble got cnt=%0d valid=%h we=%h exp 0 0 0", W_RetireCnt, W_Valid, W_RegWrite);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rand_inputs();
            reset   = ($urandom_range(0, 31) != 0);
            W_Flush = ($urandom_range(0, 7) == 0);
            W_En    = ($urandom_range(0, 3) != 0);
            tick();
            checks++; if (W_Valid !== md_valid) begin errors++; $display("FAIL rnd_valid[%0d] got %h exp %h", n, W_Valid, md_valid); end
            checks++; if (W_RegWrite !== exp_we()) begin errors++; $display("FAIL rnd_we[%0d] got %h exp %h", n, W_RegWrite, exp_we()); end
            checks++; if (W_RegAddr !== exp_addr()) begin errors++; $display("FAIL rnd_addr[%0d] got %0d exp %0d", n, W_RegAddr, exp_addr()); end
            checks++; if (W_RegData !== exp_data()) begin errors++; $display("FAIL rnd_data[%0d] got %h exp %h", n, W_RegData, exp_data()); end
            checks++; if (W_PC8 !== md_pc8) begin errors++; $display("FAIL rnd_pc8[%0d] got %h exp %h", n, W_PC8, md_pc8); end
            checks++; if (W_RetireCnt !== 4'(md_cnt)) begin errors++; $display("FAIL rnd_cnt[%0d] got %0d exp %0d", n, W_RetireCnt, md_cnt); end
        end
    endtask

    initial begin
        model_bubble();
        md_cnt = 0;
        reset = 1'b0;
        rand_inputs();
        #1;
        test_reset();
        test_byte_loads();
        test_half_loads();
        test_stall_flush();
        test_zero_guard_pc8();
        test_counter_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/w_load_pipe.md
Name: w_load_pipe

Overview:
- MEM/WB pipeline register plus write-back load-extension unit; sits directly downstream of the data memory.
- Captures the raw memory word, byte offset, ALU result, PC+8 and destination info each cycle.
- Produces the final GRF write port signals: byte/half select, sign/zero extension and write-data mux.
- Also keeps a retired-instruction counter.

Parameters:
- RETIRE_W, 32, width of the retired-instruction counter.
- RESET_PC8, 32'h0000_3008, value of W_PC8 after reset and after a flush.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  reset, synchronous and active-low (0 = reset)
- W_En  input  1  1 = capture M-stage inputs; 0 = stall (hold)
- W_Flush  input  1  1 = load a bubble at the next edge
- M_Valid  input  1  M-stage slot holds a real instruction
- M_MemoryData  input  32  word read from data memory at the word-aligned address
- M_StoreAddr  input  32  byte address of the access; only [1:0] is retained
- M_LoadType  input  3  0 none, 1 lw, 2 lh, 3 lhu, 4 lb, 5 lbu, 6-7 treated as lw
- M_ALUResult  input  32  ALU result
- M_PC8  input  32  PC+8 of the M-stage instruction
- M_RegDst  input  5  destination GRF index
- M_RegWrite  input  1  instruction writes the GRF
- M_WdSel  input  2  0 ALU result, 1 load data, 2 PC+8, 3 treated as 0
- W_RegWrite  output  1  GRF write enable
- W_RegAddr  output  5  GRF write index
- W_RegData  output  32  GRF write data
- W_PC8  output  32  registered PC+8 (for trace and forwarding)
- W_Valid  output  1  W slot holds a real instruction
- W_RetireCnt  output  RETIRE_W  count of instructions that entered W

Behaviour:
- Edge priority at each rising clk edge: reset==0, then W_Flush, then W_En==0, then capture.
- Reset (reset==0):
  - All pipeline fields cleared.
  - W_Valid=0, W_RegWrite=0, W_RegAddr=0, W_RegData=0, W_PC8=RESET_PC8, W_RetireCnt=0.
  - Applies even mid-stall or mid-flush.
- Flush: bubble loaded.
  - Valid, RegWrite, RegDst, LoadType, WdSel, offset, data and ALU fields = 0; PC8 = RESET_PC8.
  - Counter unchanged.
  - Flush wins over a simultaneous stall.
- Stall (W_En==0, no flush): every register holds, including the counter.
- Capture: all M_* fields registered.
  - Counter increments by 1 iff M_Valid==1.
  - Counter wraps from all-ones to 0 silently.
- Latency: exactly 1 cycle from M_* to W_* outputs. Outputs are combinational only from registered state; no M_* input reaches any output combinationally.
- Load extension, using the registered word D and offset A[1:0]:
  - lw: D, with A ignored.
  - lh/lhu: half = A[1] ? D[31:16] : D[15:0]; A[0] ignored. Sign-extend for lh, zero-extend for lhu.
  - lb/lbu: byte = D[8*A+7:8*A]; sign-extend for lb, zero-extend for lbu.
  - none (type 0) with WdSel=1: load data = D.
- W_RegData: mux on registered WdSel.
- W_RegWrite = registered RegWrite & registered Valid & (RegDst != 0). A write to $0 is never asserted.
- W_RegAddr: registered RegDst when W_RegWrite=1, else 0. This keeps downstream forwarding comparators clean.
- Bubbles (Valid=0) never assert W_RegWrite, even if RegWrite was captured as 1.

Optional Feature:
- Macro W_TRACE_EN.
- Defined: at every rising edge where reset==1 and W_RegWrite==1, print one line "@%h: $%d <= %h" with W_PC8-8, W_RegAddr and W_RegData. Simulation only; no effect on any port.
- Undefined: no $display present; logic identical.

Test Plan:
- Reset: hold reset=0 for 2 edges with random inputs -> W_Valid=0, W_RegWrite=0, W_RegAddr=0, W_RegData=0, W_PC8=32'h3008, W_RetireCnt=0.
- Byte loads: D=32'h80FF7F01, A=0..3, lb -> 00000001, 0000007F, FFFFFFFF, FFFFFF80; lbu at A=3 -> 00000080.
- Halfword loads: D=32'h8001_7FFE; lh A=0 -> 00007FFE, lh A=2 -> FFFF8001, lhu A=2 -> 00008001, lh A=3 -> FFFF8001 (A[0] ignored).
- Stall then flush: capture ALU write to $5 of 32'h1234, then W_En=0 for 3 cycles -> outputs and counter hold. Then W_Flush=1 with W_En=0 -> next cycle W_Valid=0, W_RegWrite=0, W_PC8=32'h3008, counter unchanged.
- $0 guard and PC+8: M_RegDst=0, RegWrite=1, WdSel=0 -> W_RegWrite=0, W_RegAddr=0. Then jal with M_PC8=32'h3010, RegDst=31, WdSel=2 -> W_RegData=32'h3010, W_RegAddr=31.
- Counter wrap: RETIRE_W=4, 16 consecutive valid captures plus 1 bubble (M_Valid=0) -> counter reads 0 after 16 captures and is still 0 after the bubble.
